// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns every HI/LO write.
// Restoring radix-2 division on magnitudes, then a sign fix-up cycle.
module muldiv_seq #(
  parameter int MUL_STAGES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic        hilowe,
  output logic [31:0] hi_i,
  output logic [31:0] lo_i
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  localparam logic [1:0] MCNT_LAST = 2'(MUL_STAGES - 1);

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem;
  logic [31:0] quo;
  logic        sign_q;
  logic        sign_r;
  logic [1:0]  mcnt;
  logic [4:0]  dcnt;

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_signed;

  // Sign-extending for MULT lets one 64-bit truncating multiply serve both ops.
  always_comb begin
    mul_a   = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    mul_b   = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    product = mul_a * mul_b;
  end

  always_comb begin
    shifted    = {rem, quo[31]};
    diff       = shifted - {1'b0, b_q};
    div_signed = ~op[0];
    abs_a      = (div_signed && src_a[31]) ? -src_a : src_a;
    abs_b      = (div_signed && src_b[31]) ? -src_b : src_b;
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign hilowe = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= 2'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      mcnt   <= 2'd0;
      dcnt   <= 5'd0;
      hi_i   <= 32'd0;
      lo_i   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            op_q <= op;
            a_q  <= src_a;
            b_q  <= src_b;
            mcnt <= 2'd0;
            dcnt <= 5'd0;
            if (!op[1]) begin
              state <= MUL;
            end else if (src_b == 32'd0) begin
              hi_i  <= src_a;
              lo_i  <= 32'hFFFF_FFFF;
              state <= DONE;
            end else begin
              b_q    <= abs_b;
              rem    <= 32'd0;
              quo    <= abs_a;
              sign_q <= div_signed & (src_a[31] ^ src_b[31]);
              sign_r <= div_signed & src_a[31];
              state  <= DIV;
            end
          end
        end
        MUL: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (mcnt == 2'd0) {rem, quo} <= product;
            mcnt <= mcnt + 2'd1;
            if (mcnt == MCNT_LAST) begin
              {hi_i, lo_i} <= (mcnt == 2'd0) ? product : {rem, quo};
              state        <= DONE;
            end
          end
        end
        DIV: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (!diff[32]) begin
              rem <= diff[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= shifted[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            dcnt <= dcnt + 5'd1;
            if (dcnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            lo_i  <= sign_q ? -quo : quo;
            hi_i  <= sign_r ? -rem : rem;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO and latency,
// a negedge monitor pops and compares on every hilowe pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic        hilowe;
  logic [31:0] hi_i;
  logic [31:0] lo_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   writes = 0;
  int   tests = 0;
  int   failed = 0;

  muldiv_seq #(.MUL_STAGES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .cancel(cancel), .busy(busy), .done(done),
    .hilowe(hilowe), .hi_i(hi_i), .lo_i(lo_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every HI/LO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (hilowe) begin
      writes++;
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_write: got hi=0x%0h lo=0x%0h, expected no write",
                 hi_i, lo_i);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("hi", {32'd0, hi_i}, {32'd0, e.hi});
        check_output("lo", {32'd0, lo_i}, {32'd0, e.lo});
        check_output("latency", 64'(cyc - e.acc), 64'(e.lat));
        check_output("done_with_hilowe", {63'd0, done}, 64'd1);
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi,
                                input logic [31:0] elo, input int lat,
                                input bit intrude);
    int n;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    sb.push_back('{ehi, elo, lat, cyc});
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      start = (intrude && n == 5);
      if (intrude && n == 5) op = 2'd0;
      @(negedge clk);
    end
    start = 1'b0;
    check_output("busy_cycles", 64'(n), 64'(lat));
  endtask

  task automatic start_untracked(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int          w0;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;

    repeat (3) @(negedge clk);
    check_output("reset_outputs", {busy, done, hilowe, hi_i, lo_i}, 64'd0);
    rst_n = 1'b1;

    // start with cancel in IDLE must be ignored
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'd0; src_a = 32'd4; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check_output("start_with_cancel_ignored", {63'd0, busy}, 64'd0);

    apply_stimulus(2'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 0);
    apply_stimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 2, 0);
    repeat (3) @(negedge clk);
    check_output("hold_after_done", {hi_i, lo_i}, 64'hFFFF_FFFE_0000_0001);

    apply_stimulus(2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
    apply_stimulus(2'd3, 32'd100,       32'd7,          32'd2,         32'd14,        34, 0);
    apply_stimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 34, 0);
    apply_stimulus(2'd2, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 34, 0);
    apply_stimulus(2'd3, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1,  0);
    apply_stimulus(2'd3, 32'd1000,      32'd10,         32'd0,         32'd100,       34, 1);
    repeat (4) @(negedge clk);
    check_output("intrude_no_extra_busy", {63'd0, busy}, 64'd0);

    // cancel mid-divide: no write, HI/LO data untouched
    hold_hi = hi_i;
    hold_lo = lo_i;
    w0 = writes;
    start_untracked(2'd2, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_output("cancel_to_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check_output("cancel_no_write", 64'(writes - w0), 64'd0);
    check_output("cancel_hold", {hi_i, lo_i}, {hold_hi, hold_lo});

    // reset mid-divide clears everything and writes nothing
    w0 = writes;
    start_untracked(2'd2, 32'd12345, 32'd6);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("reset_mid_div", {busy, done, hilowe, hi_i, lo_i}, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_output("reset_no_write", 64'(writes - w0), 64'd0);

    apply_stimulus(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0);
    repeat (2) @(negedge clk);
    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
